// File: rtl/adsp21xx_loop_ctrl_pkg.sv
// adsp21xx_loop_ctrl_pkg: shared widths, condition codes and loop-stack entry type
// Contents:
//   AW            program/counter address width
//   CC_CE         term code meaning "loop until counter expired"
//   CC_TRUE       always-true condition code
//   loop_entry_t  loop-stack entry {end address, termination condition}
package adsp21xx_loop_ctrl_pkg;
    localparam int AW = 14;
    localparam logic [3:0] CC_CE = 4'hE;
    localparam logic [3:0] CC_TRUE = 4'hF;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    term;
    } loop_entry_t;
endpackage

// File: rtl/adsp21xx_lifo.sv
// adsp21xx_lifo: small LIFO with pop-before-push ordering and sticky overflow
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   ce_i           clock enable for all state
//   push_i/din_i   push request and data
//   pop_i          pop request (ignored when empty)
//   top_o          top entry, 0 when empty
//   empty_o/full_o occupancy flags
//   ovf_o          sticky: a push was discarded because the stack was full
module adsp21xx_lifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ce_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] top_o,
    output logic         empty_o,
    output logic         full_o,
    output logic         ovf_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d, mid, top_idx;
    logic          ovf_q, ovf_d, do_pop, do_push;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign ovf_o   = ovf_q;
    assign top_idx = cnt_q - CW'(1);
    assign top_o   = empty_o ? '0 : mem_q[top_idx[IW-1:0]];
    // The pop is applied first, so pop+push on a full stack replaces the top instead of overflowing.
    always_comb begin
        do_pop  = pop_i & ~empty_o;
        mid     = cnt_q - CW'(do_pop);
        do_push = push_i & (mid != CW'(DEPTH));
        cnt_d   = mid + CW'(do_push);
        ovf_d   = ovf_q | (push_i & ~do_push);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (ce_i) begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (do_push) mem_q[mid[IW-1:0]] <= din_i;
        end
    end
endmodule

// File: rtl/adsp21xx_loop_ctrl.sv
// adsp21xx_loop_ctrl: sequencer loop/counter controller (CNTR, count stack, loop stack)
// Ports:
//   clk_i, rst_i, ce_i          clock, synchronous active-high reset, clock enable
//   fetch_val_i, fetch_addr_i   current fetch, compared against top loop end address
//   do_push_i, do_addr_i/term_i DO UNTIL push of {end addr, term cond}
//   cntr_we_i, cntr_di_i        CNTR load (saves old CNTR on count stack)
//   cntr_dec_i                  CE-test decrement request
//   cnpop_i, lppop_i            explicit count/loop stack pops
//   loop_cond_i                 external evaluation of top_term_o
//   cntr_o, ce_flag_o           counter and expired flag (CNTR==1)
//   top_term_o                  term cond of top loop entry, 0 when empty
//   loop_back_o, loop_exit_o    combinational loop-end decision, gated by ce_i
//   ls/cs_empty_o, ls/cs_ovf_o  stack status
module adsp21xx_loop_ctrl
    import adsp21xx_loop_ctrl_pkg::*;
#(
    parameter int AW         = adsp21xx_loop_ctrl_pkg::AW,
    parameter int LOOP_DEPTH = 4,
    parameter int CNT_DEPTH  = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ce_i,
    input  logic          fetch_val_i,
    input  logic [AW-1:0] fetch_addr_i,
    input  logic          do_push_i,
    input  logic [AW-1:0] do_addr_i,
    input  logic [3:0]    do_term_i,
    input  logic          cntr_we_i,
    input  logic [AW-1:0] cntr_di_i,
    input  logic          cntr_dec_i,
    input  logic          cnpop_i,
    input  logic          lppop_i,
    input  logic          loop_cond_i,
    output logic [AW-1:0] cntr_o,
    output logic          ce_flag_o,
    output logic [3:0]    top_term_o,
    output logic          loop_back_o,
    output logic          loop_exit_o,
    output logic          ls_empty_o,
    output logic          cs_empty_o,
    output logic          ls_ovf_o,
    output logic          cs_ovf_o
);
    logic [AW-1:0] cntr_q, cntr_d, cs_top;
    loop_entry_t   ls_top, ls_din;
    logic          ls_full, cs_full, is_ce, loop_end, done, ls_pop, cs_pop;
    assign ls_din     = '{addr: do_addr_i, term: do_term_i};
    assign cntr_o     = cntr_q;
    assign ce_flag_o  = cntr_q == AW'(1);
    assign top_term_o = ls_top.term;
    assign is_ce      = ls_top.term == CC_CE;
    assign loop_end   = ce_i & fetch_val_i & ~ls_empty_o & (fetch_addr_i == ls_top.addr);
    assign done       = is_ce ? ce_flag_o : loop_cond_i;
    assign loop_exit_o = loop_end & done;
    assign loop_back_o = loop_end & ~done;
    assign ls_pop     = loop_exit_o | lppop_i;
    assign cs_pop     = (loop_exit_o & is_ce) | cnpop_i;
    // Priority for the new CNTR: load > count-stack pop > decrement.
    always_comb begin
        cntr_d = cntr_q;
        if ((loop_back_o & is_ce) | (cntr_dec_i & ~ce_flag_o)) cntr_d = cntr_q - AW'(1);
        if (cs_pop & ~cs_empty_o) cntr_d = cs_top;
        if (cntr_we_i) cntr_d = cntr_di_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) cntr_q <= '0;
        else if (ce_i) cntr_q <= cntr_d;
    end
    adsp21xx_lifo #(.W($bits(loop_entry_t)), .DEPTH(LOOP_DEPTH)) u_ls (
        .clk_i(clk_i), .rst_i(rst_i), .ce_i(ce_i),
        .push_i(do_push_i), .pop_i(ls_pop), .din_i(ls_din),
        .top_o(ls_top), .empty_o(ls_empty_o), .full_o(ls_full), .ovf_o(ls_ovf_o)
    );
    adsp21xx_lifo #(.W(AW), .DEPTH(CNT_DEPTH)) u_cs (
        .clk_i(clk_i), .rst_i(rst_i), .ce_i(ce_i),
        .push_i(cntr_we_i), .pop_i(cs_pop), .din_i(cntr_q),
        .top_o(cs_top), .empty_o(cs_empty_o), .full_o(cs_full), .ovf_o(cs_ovf_o)
    );
endmodule

// File: tb/tb_adsp21xx_loop_ctrl.sv
// tb_adsp21xx_loop_ctrl: directed stimulus, queue-based reference model and literal spot checks
module tb_adsp21xx_loop_ctrl;
    logic clk = 0, rst = 1, ce = 1;
    logic fv = 0, dp = 0, cwe = 0, cdec = 0, cnpop = 0, lppop = 0, lcond = 0;
    logic [13:0] fa = 0, da = 0, cdi = 0;
    logic [3:0] dt = 0;
    logic [13:0] cntr;
    logic [3:0] topterm;
    logic ceflag, lback, lexit, lse, cse, lsovf, csovf;
    int vectors = 0, miscompares = 0;

    adsp21xx_loop_ctrl dut (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .fetch_val_i(fv), .fetch_addr_i(fa),
        .do_push_i(dp), .do_addr_i(da), .do_term_i(dt), .cntr_we_i(cwe), .cntr_di_i(cdi),
        .cntr_dec_i(cdec), .cnpop_i(cnpop), .lppop_i(lppop), .loop_cond_i(lcond),
        .cntr_o(cntr), .ce_flag_o(ceflag), .top_term_o(topterm), .loop_back_o(lback),
        .loop_exit_o(lexit), .ls_empty_o(lse), .cs_empty_o(cse), .ls_ovf_o(lsovf), .cs_ovf_o(csovf)
    );

    always #5 clk = ~clk;

    // Reference model: loop stack entries are {addr,term}, top at the back of the queue.
    logic [17:0] m_ls [$];
    logic [13:0] m_cs [$];
    logic [13:0] m_cntr = 0;
    logic m_lsovf = 0, m_csovf = 0;

    function automatic logic [3:0] m_term();
        return m_ls.size() == 0 ? 4'h0 : m_ls[$][3:0];
    endfunction

    // {back, exit}
    function automatic logic [1:0] m_decide();
        logic hit, fin;
        hit = ce && fv && m_ls.size() != 0 && m_ls[$][17:4] == fa;
        fin = (m_term() == 4'hE) ? (m_cntr == 1) : lcond;
        return {hit && !fin, hit && fin};
    endfunction

    always @(posedge clk) begin
        logic [1:0] be;
        logic [13:0] nc;
        logic ce_loop;
        be = m_decide();
        ce_loop = m_term() == 4'hE;
        if (rst) begin
            m_ls.delete(); m_cs.delete(); m_cntr = 0; m_lsovf = 0; m_csovf = 0;
        end else if (ce) begin
            nc = m_cntr;
            if (be[1] && ce_loop) nc = m_cntr - 1;
            if (cdec && m_cntr != 1) nc = m_cntr - 1;
            if (((be[0] && ce_loop) || cnpop) && m_cs.size() != 0) nc = m_cs.pop_back();
            if (cwe) begin
                if (m_cs.size() < 4) m_cs.push_back(m_cntr); else m_csovf = 1;
                nc = cdi;
            end
            m_cntr = nc;
            if ((be[0] || lppop) && m_ls.size() != 0) void'(m_ls.pop_back());
            if (dp) begin
                if (m_ls.size() < 4) m_ls.push_back({da, dt}); else m_lsovf = 1;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [1:0] be;
        be = m_decide();
        cmp("cntr", cntr, m_cntr);
        cmp("ce_flag", ceflag, m_cntr == 1);
        cmp("top_term", topterm, m_term());
        cmp("loop_back", lback, be[1]);
        cmp("loop_exit", lexit, be[0]);
        cmp("ls_empty", lse, m_ls.size() == 0);
        cmp("cs_empty", cse, m_cs.size() == 0);
        cmp("ls_ovf", lsovf, m_lsovf);
        cmp("cs_ovf", csovf, m_csovf);
    end

    task automatic step();
        @(posedge clk);
        #1;
        fv = 0; dp = 0; cwe = 0; cdec = 0; cnpop = 0; lppop = 0; lcond = 0;
    endtask

    task automatic load(input logic [13:0] v);
        cwe = 1; cdi = v; step();
    endtask

    task automatic push(input logic [13:0] a, input logic [3:0] t);
        dp = 1; da = a; dt = t; step();
    endtask

    task automatic fetch(input logic [13:0] a, input logic c);
        fv = 1; fa = a; lcond = c; #1;
    endtask

    initial begin
        step(); step();
        cmp("reset cntr", cntr, 0);
        cmp("reset ls_empty", lse, 1);
        cmp("reset top_term", topterm, 0);
        rst = 0;
        step();
        // DO UNTIL CE, CNTR=3
        load(3);
        push(14'h105, 4'hE);
        fetch(14'h105, 0); cmp("t1 back1", lback, 1); cmp("t1 cntr3", cntr, 3); step();
        fetch(14'h105, 0); cmp("t1 back2", lback, 1); cmp("t1 cntr2", cntr, 2); step();
        fetch(14'h105, 0); cmp("t1 exit", lexit, 1); cmp("t1 cntr1", cntr, 1); step();
        #1; cmp("t1 cntr restored", cntr, 0); cmp("t1 ls empty", lse, 1); cmp("t1 cs empty", cse, 1);
        // nested CE loops
        load(2); push(14'h200, 4'hE); load(4); push(14'h150, 4'hE);
        repeat (3) begin fetch(14'h150, 0); step(); end
        fetch(14'h150, 0); cmp("t2 inner exit", lexit, 1); step();
        #1; cmp("t2 cntr outer", cntr, 2); cmp("t2 top outer", topterm, 4'hE);
        fetch(14'h200, 0); cmp("t2 outer back", lback, 1); step();
        fetch(14'h200, 0); cmp("t2 outer exit", lexit, 1); step();
        #1; cmp("t2 ls empty", lse, 1); cmp("t2 cntr0", cntr, 0);
        // non-CE termination
        load(7); push(14'h300, 4'h0);
        fetch(14'h300, 0); cmp("t3 back1", lback, 1); step();
        fetch(14'h300, 0); cmp("t3 back2", lback, 1); step();
        fetch(14'h300, 1); cmp("t3 exit", lexit, 1); step();
        #1; cmp("t3 cntr untouched", cntr, 7);
        cnpop = 1; step();
        // loop stack overflow and empty pops
        for (int i = 0; i < 5; i++) push(14'h10 + 14'(i), 4'(i + 1));
        #1; cmp("t4 ls_ovf", lsovf, 1); cmp("t4 top 4th", topterm, 4);
        fetch(14'h13, 0); cmp("t4 back on 4th", lback, 1); step();
        repeat (6) begin lppop = 1; step(); end
        #1; cmp("t4 ls empty", lse, 1); cmp("t4 top zero", topterm, 0);
        fetch(14'h13, 0); cmp("t4 no loop", lback, 0); step();
        // same-cycle ordering
        push(14'h400, 4'h0);
        fetch(14'h400, 1); dp = 1; da = 14'h500; dt = 4'h3; step();
        #1; cmp("t5 ls not empty", lse, 0); cmp("t5 top new", topterm, 3);
        push(14'h600, 4'h0);
        fetch(14'h600, 1); lppop = 1; step();
        #1; cmp("t5 single pop", topterm, 3);
        fetch(14'h500, 0); cmp("t5 back new", lback, 1); step();
        cwe = 1; cdi = 5; cdec = 1; step();
        #1; cmp("t5 we beats dec", cntr, 5);
        load(1); cdec = 1; step();
        #1; cmp("t5 expired no dec", cntr, 1);
        cdec = 1; cdi = 9; ce = 0; cwe = 1; fetch(14'h500, 0);
        cmp("t5 ce0 no back", lback, 0); step();
        ce = 1; #1; cmp("t5 ce0 hold", cntr, 1);
        repeat (6) begin cnpop = 1; step(); end
        repeat (5) load(14'h20);
        #1; cmp("t5 cs_ovf", csovf, 1);
        // reset mid-loop
        repeat (3) begin lppop = 1; step(); end
        load(3); push(14'h700, 4'hE); push(14'h710, 4'hE);
        rst = 1; step(); rst = 0;
        fetch(14'h710, 0);
        cmp("t6 back", lback, 0); cmp("t6 exit", lexit, 0); cmp("t6 cntr", cntr, 0); cmp("t6 ovf clr", csovf, 0);
        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
